// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared Q-format constants, FSM states, cfg fields and saturation helper
package iir_pkg;

    localparam int FRAC     = 12;
    localparam int SAMPLE_W = 16;
    localparam int PROD_W   = 32;
    localparam int ACC_W    = 40;

    localparam int CFG_COEF_LSB = 0;
    localparam int CFG_COEF_W   = 16;
    localparam int CFG_DLY_LSB  = 16;
    localparam int CFG_DLY_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    // Returns {clipped, sample}: accumulator scaled back to Q4.12 (floor), clamped to 16 bits.
    function automatic logic [SAMPLE_W:0] sat16(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> FRAC;
        if (sh > 40'sd32767) begin
            return {1'b1, 16'h7FFF};
        end else if (sh < -40'sd32768) begin
            return {1'b1, 16'h8000};
        end else begin
            return {1'b0, sh[SAMPLE_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/iir_mac_unit.sv
// rtl/iir_mac_unit.sv - shared 16x16 multiply with 40-bit add/subtract accumulator
module iir_mac_unit
    import iir_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] coef,
    input  logic signed [SAMPLE_W-1:0] operand,
    input  logic                       sub,
    input  logic                       clr,
    input  logic                       en,
    output logic signed [ACC_W-1:0]    acc
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    // Full-precision Q8.24 product, then clear / accumulate / subtract.
    always_comb begin
        prod  = PROD_W'(coef) * PROD_W'(operand);
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = sub ? (acc_q - ACC_W'(prod)) : (acc_q + ACC_W'(prod));
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/iir_tap_scheduler.sv
// rtl/iir_tap_scheduler.sv - time-multiplexed IIR controller: FSM, history buffers, tap table
module iir_tap_scheduler
    import iir_pkg::*;
#(
    parameter int NB   = 3,
    parameter int NA   = 6,
    parameter int HIST = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [SAMPLE_W-1:0] x_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] y_out,
    output logic                       y_sat,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_addr,
    input  logic [19:0]                cfg_data,
    output logic                       cfg_err,
    output logic                       busy
);

    localparam int NT = NB + NA;
    localparam int PW = $clog2(HIST);
    localparam int TW = 4;

    state_e                     state_q, state_d;
    logic [TW-1:0]              tap_q, tap_d;
    logic [PW-1:0]              wptr_q, wptr_d;
    logic                       cfg_err_q, cfg_err_d;
    logic signed [SAMPLE_W-1:0] coef_q [NT];
    logic signed [SAMPLE_W-1:0] coef_d [NT];
    logic [CFG_DLY_W-1:0]       dly_q  [NT];
    logic [CFG_DLY_W-1:0]       dly_d  [NT];
    logic signed [SAMPLE_W-1:0] x_hist_q [HIST];
    logic signed [SAMPLE_W-1:0] x_hist_d [HIST];
    logic signed [SAMPLE_W-1:0] y_hist_q [HIST];
    logic signed [SAMPLE_W-1:0] y_hist_d [HIST];

    logic signed [SAMPLE_W-1:0] cur_coef;
    logic [CFG_DLY_W-1:0]       cur_dly;
    logic [PW-1:0]              rd_ptr;
    logic                       is_fb;
    logic signed [SAMPLE_W-1:0] operand;
    logic                       mac_clr;
    logic                       mac_en;
    logic signed [ACC_W-1:0]    acc;
    logic [SAMPLE_W:0]          sat_w;
    logic                       cfg_addr_ok;

    // Current tap's coefficient and history operand; feedback with d=0 would read y[n], so it reads 0.
    always_comb begin
        cur_coef = coef_q[tap_q];
        cur_dly  = dly_q[tap_q];
        rd_ptr   = wptr_q - PW'(cur_dly);
        is_fb    = ({1'b0, tap_q} >= 5'(NB));
        if (is_fb) begin
            operand = (cur_dly == '0) ? '0 : y_hist_q[rd_ptr];
        end else begin
            operand = x_hist_q[rd_ptr];
        end
    end

    iir_mac_unit u_mac (
        .clk     (clk),
        .rst     (rst),
        .coef    (cur_coef),
        .operand (operand),
        .sub     (is_fb),
        .clr     (mac_clr),
        .en      (mac_en),
        .acc     (acc)
    );

    assign sat_w       = sat16(acc);
    assign y_out       = sat_w[SAMPLE_W-1:0];
    assign y_sat       = sat_w[SAMPLE_W];
    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_OUT);
    assign busy        = (state_q != ST_IDLE);
    assign cfg_err     = cfg_err_q;
    assign cfg_addr_ok = ({1'b0, cfg_addr} < 5'(NT));

    // Sequencing: accept sample, walk the tap list, hold result, commit history on handshake; tap table writes.
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        wptr_d    = wptr_q;
        x_hist_d  = x_hist_q;
        y_hist_d  = y_hist_q;
        coef_d    = coef_q;
        dly_d     = dly_q;
        cfg_err_d = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x_hist_d[wptr_q] = x_in;
                    mac_clr          = 1'b1;
                    tap_d            = '0;
                    state_d          = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (tap_q == TW'(NT - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    tap_d = tap_q + TW'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    y_hist_d[wptr_q] = y_out;
                    wptr_d           = wptr_q + PW'(1);
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cfg_we) begin
            if ((state_q == ST_IDLE) && cfg_addr_ok) begin
                coef_d[cfg_addr] = cfg_data[CFG_COEF_LSB +: CFG_COEF_W];
                dly_d[cfg_addr]  = cfg_data[CFG_DLY_LSB +: CFG_DLY_W];
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // State, pointers, tap table and history buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            tap_q     <= '0;
            wptr_q    <= '0;
            cfg_err_q <= 1'b0;
            coef_q    <= '{default: '0};
            dly_q     <= '{default: '0};
            x_hist_q  <= '{default: '0};
            y_hist_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            tap_q     <= tap_d;
            wptr_q    <= wptr_d;
            cfg_err_q <= cfg_err_d;
            coef_q    <= coef_d;
            dly_q     <= dly_d;
            x_hist_q  <= x_hist_d;
            y_hist_q  <= y_hist_d;
        end
    end

endmodule

// File: tb/tb_iir_tap_scheduler.sv
// tb/tb_iir_tap_scheduler.sv - self-checking bench for iir_tap_scheduler against a difference-equation model
module tb_iir_tap_scheduler;

    localparam int NB   = 3;
    localparam int NA   = 6;
    localparam int HIST = 16;
    localparam int NT   = NB + NA;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] y_out;
    logic        y_sat;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [19:0] cfg_data = '0;
    logic        cfg_err;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: tap table and every sample / result since the last reset.
    int m_coef [NT];
    int m_dly  [NT];
    int xs [$];
    int ys [$];

    iir_tap_scheduler #(.NB(NB), .NA(NA), .HIST(HIST)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_out     (y_out),
        .y_sat     (y_sat),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int k = 0; k < NT; k++) begin
            m_coef[k] = 0;
            m_dly[k]  = 0;
        end
        xs.delete();
        ys.delete();
    endfunction

    // y[n] = sum b_k x[n-d_k] - sum a_k y[n-d_k] (a_k with d=0 ignored), floor to Q4.12, clamp.
    function automatic void model_step(input int x, output logic [15:0] y, output logic s);
        longint acc;
        longint sh;
        int n;
        int d;
        acc = 0;
        xs.push_back(x);
        n = xs.size() - 1;
        for (int k = 0; k < NT; k++) begin
            d = m_dly[k];
            if (n - d >= 0) begin
                if (k < NB) begin
                    acc += longint'(m_coef[k]) * longint'(xs[n - d]);
                end else if (d != 0) begin
                    acc -= longint'(m_coef[k]) * longint'(ys[n - d]);
                end
            end
        end
        sh = acc >>> 12;
        if (sh > 32767) begin
            y = 16'h7FFF;
            s = 1'b1;
        end else if (sh < -32768) begin
            y = 16'h8000;
            s = 1'b1;
        end else begin
            y = sh[15:0];
            s = 1'b0;
        end
        ys.push_back(int'($signed(y)));
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cfg_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [3:0] d, input logic [15:0] c, input bit exp_err);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = {d, c};
        @(posedge clk); #1;
        cfg_we = 1'b0;
        tests_run++;
        if (cfg_err !== exp_err) begin
            tests_failed++;
            $display("FAIL cfg_err_pulse addr=%0d got %b want %b", a, cfg_err, exp_err);
        end
        @(posedge clk); #1;
        tests_run++;
        if (cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL cfg_err_one_cycle addr=%0d got %b want 0", a, cfg_err);
        end
        if (!exp_err) begin
            m_coef[a] = int'($signed(c));
            m_dly[a]  = int'(d);
        end
    endtask

    // One sample through the DUT; optional same-cycle cfg write, optional rejected write during MAC.
    task automatic send_sample(input logic [15:0] x, input int stall, input bit poke,
                               input bit with_cfg, input logic [3:0] ca, input logic [19:0] cd,
                               output logic [15:0] y_act, output logic s_act);
        logic [15:0] ey;
        logic        es;
        logic [15:0] held;
        int          cyc;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL in_ready_idle got %b want 1", in_ready);
        end
        if (with_cfg) begin
            cfg_we   = 1'b1;
            cfg_addr = ca;
            cfg_data = cd;
            m_coef[ca] = int'($signed(cd[15:0]));
            m_dly[ca]  = int'(cd[19:16]);
        end
        in_valid = 1'b1;
        x_in     = x;
        model_step(int'($signed(x)), ey, es);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        if (with_cfg) begin
            tests_run++;
            if (cfg_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL cfg_same_cycle_err got %b want 0", cfg_err);
            end
        end
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 200) begin
            if (poke && cyc == 3) begin
                cfg_we   = 1'b1;
                cfg_addr = 4'd0;
                cfg_data = 20'h07000;
            end
            @(posedge clk); #1;
            cfg_we = 1'b0;
            if (poke && cyc == 3) begin
                tests_run++;
                if (cfg_err !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL cfg_err_in_mac got %b want 1", cfg_err);
                end
            end
            if (poke && cyc == 4) begin
                tests_run++;
                if (cfg_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL cfg_err_in_mac_clear got %b want 0", cfg_err);
                end
            end
            cyc++;
        end
        tests_run++;
        if (cyc != NT + 1) begin
            tests_failed++;
            $display("FAIL out_latency got %0d want %0d", cyc, NT + 1);
        end
        tests_run++;
        if (y_out !== ey) begin
            tests_failed++;
            $display("FAIL y_out_model x=%h got %h want %h", x, y_out, ey);
        end
        tests_run++;
        if (y_sat !== es) begin
            tests_failed++;
            $display("FAIL y_sat_model x=%h got %b want %b", x, y_sat, es);
        end
        y_act = y_out;
        s_act = y_sat;
        held  = y_out;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || y_out !== held || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_hold cyc=%0d got v=%b y=%h rdy=%b want v=1 y=%h rdy=0",
                         i, out_valid, y_out, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_handshake got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        logic [15:0] y;
        logic        s;
        do_reset();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y_out !== 16'h0000 ||
            y_sat !== 1'b0 || cfg_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got rdy=%b v=%b y=%h sat=%b err=%b busy=%b want 1 0 0000 0 0 0",
                     in_ready, out_valid, y_out, y_sat, cfg_err, busy);
        end
        cfg_write(4'd0, 4'd0, 16'h1000, 1'b0);
        in_valid = 1'b1;
        x_in     = 16'h1234;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_in_mac got %b want 1", busy);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_abort got v=%b busy=%b rdy=%b want 0 0 1", out_valid, busy, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        cfg_write(4'd0, 4'd0, 16'h1000, 1'b0);
        send_sample(16'h0A5A, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
        tests_run++;
        if (y !== 16'h0A5A) begin
            tests_failed++;
            $display("FAIL reset_passthrough got %h want 0a5a", y);
        end
    endtask

    task automatic test_passthrough();
        logic [15:0] y;
        logic        s;
        do_reset();
        cfg_write(4'd0, 4'd0, 16'h1000, 1'b0);
        send_sample(16'h0800, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
        tests_run++;
        if (y !== 16'h0800 || s !== 1'b0) begin
            tests_failed++;
            $display("FAIL passthrough got %h sat=%b want 0800 sat=0", y, s);
        end
    endtask

    task automatic test_sparse_delay();
        logic [15:0] y;
        logic [15:0] want;
        logic        s;
        do_reset();
        cfg_write(4'd0, 4'd6, 16'h1000, 1'b0);
        for (int n = 0; n < 24; n++) begin
            send_sample((n == 0) ? 16'h1000 : 16'h0000, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
            want = (n == 6) ? 16'h1000 : 16'h0000;
            tests_run++;
            if (y !== want) begin
                tests_failed++;
                $display("FAIL sparse_delay n=%0d got %h want %h", n, y, want);
            end
        end
    endtask

    task automatic test_feedback();
        logic [15:0] y;
        logic        s;
        logic [15:0] exp1 [4];
        logic [15:0] exp0 [3];
        exp1 = '{16'h1000, 16'hF800, 16'h0400, 16'hFE00};
        exp0 = '{16'h1000, 16'h0000, 16'h0000};
        do_reset();
        cfg_write(4'd0, 4'd0, 16'h1000, 1'b0);
        cfg_write(4'd3, 4'd1, 16'h0800, 1'b0);
        for (int n = 0; n < 4; n++) begin
            send_sample((n == 0) ? 16'h1000 : 16'h0000, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
            tests_run++;
            if (y !== exp1[n]) begin
                tests_failed++;
                $display("FAIL feedback_d1 n=%0d got %h want %h", n, y, exp1[n]);
            end
        end
        do_reset();
        cfg_write(4'd0, 4'd0, 16'h1000, 1'b0);
        cfg_write(4'd3, 4'd0, 16'h0800, 1'b0);
        for (int n = 0; n < 3; n++) begin
            send_sample((n == 0) ? 16'h1000 : 16'h0000, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
            tests_run++;
            if (y !== exp0[n]) begin
                tests_failed++;
                $display("FAIL feedback_d0 n=%0d got %h want %h", n, y, exp0[n]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] y;
        logic        s;
        do_reset();
        cfg_write(4'd0, 4'd0, 16'h7FFF, 1'b0);
        cfg_write(4'd1, 4'd0, 16'h7FFF, 1'b0);
        send_sample(16'h7FFF, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
        tests_run++;
        if (y !== 16'h7FFF || s !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_pos got %h sat=%b want 7fff sat=1", y, s);
        end
        send_sample(16'h8000, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
        tests_run++;
        if (y !== 16'h8000 || s !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_neg got %h sat=%b want 8000 sat=1", y, s);
        end
    endtask

    task automatic test_backpressure_cfg();
        logic [15:0] y;
        logic        s;
        do_reset();
        cfg_write(4'd0, 4'd0, 16'h1000, 1'b0);
        cfg_write(4'd1, 4'd1, 16'h0800, 1'b0);
        send_sample(16'h0300, 5, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
        send_sample(16'h0100, 0, 1'b1, 1'b0, 4'd0, 20'h0, y, s);
        send_sample(16'h0200, 0, 1'b0, 1'b0, 4'd0, 20'h0, y, s);
        tests_run++;
        if (y !== 16'h0280) begin
            tests_failed++;
            $display("FAIL cfg_dropped_result got %h want 0280", y);
        end
        cfg_write(4'd12, 4'd0, 16'h1000, 1'b1);
        cfg_write(4'd9, 4'd0, 16'h1000, 1'b1);
        send_sample(16'h0040, 0, 1'b0, 1'b1, 4'd1, 20'h0_2000, y, s);
        tests_run++;
        if (y !== 16'h00C0) begin
            tests_failed++;
            $display("FAIL cfg_same_cycle_result got %h want 00c0", y);
        end
    endtask

    task automatic test_random();
        logic [15:0] y;
        logic        s;
        logic [19:0] cd;
        do_reset();
        for (int k = 0; k < NT; k++) begin
            cfg_write(4'(k), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 8191) - 4096), 1'b0);
        end
        for (int n = 0; n < 40; n++) begin
            cd = {4'($urandom_range(0, 15)), 16'($urandom_range(0, 6143) - 3072)};
            send_sample(16'($urandom), int'($urandom_range(0, 2)), 1'b0,
                        ($urandom_range(0, 4) == 0), 4'($urandom_range(0, NT - 1)), cd, y, s);
            if ($urandom_range(0, 9) == 0) begin
                cfg_write(4'($urandom_range(NT, 15)), 4'd1, 16'h1234, 1'b1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_sparse_delay();
        test_feedback();
        test_saturation();
        test_backpressure_cfg();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/iir_tap_scheduler.md
# iir_tap_scheduler

Time-multiplexed controller for the team's IIR difference-equation datapath. It accepts input samples over a valid/ready handshake and keeps circular x/y history buffers. A single shared multiply-accumulate unit steps through a programmable list of feedforward and feedback taps, one tap per cycle, and each result is returned over a second valid/ready handshake. Coefficients and tap delays are loaded through a configuration port, so one block covers sparse equations such as y[n] = x[n-6] - 1.25x[n-8] + ... without per-index hardwired branches.

## Interface
- NB, 3: number of feedforward tap slots (1..8)
- NA, 6: number of feedback tap slots (1..8)
- HIST, 16: history depth per buffer; power of 2, at least 16
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  input sample present
- in_ready  out  1  block accepts a sample
- x_in  in  16  signed sample, Q4.12
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts the result
- y_out  out  16  signed result, Q4.12
- y_sat  out  1  y_out was saturated; qualified by out_valid
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  4  tap slot: 0..NB-1 feedforward, NB..NB+NA-1 feedback
- cfg_data  in  20  [19:16] delay d, [15:0] signed coefficient, Q4.12
- cfg_err  out  1  one-cycle pulse when a write is rejected
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, MAC, OUT.
- **IDLE:** in_ready=1. On in_valid, x_in is written to x_hist[wptr], acc is cleared, tap=0, and the FSM goes to MAC.
- **MAC:** one tap per cycle, tap = 0..NB+NA-1.
  - Feedforward slot k: acc += b_k * x_hist[(wptr - d_k) mod HIST].
  - Feedback slot k: acc -= a_k * y_hist[(wptr - d_k) mod HIST].
  - A feedback slot with d=0 contributes 0; y[n] is never read.
  - Address arithmetic wraps modulo HIST.
  - After the last tap, the FSM goes to OUT.
- **OUT:** out_valid=1. y_out = sat16(acc >>> 12) and y_sat is set if clipping occurred. Both hold stable until out_ready. On the handshake:
  - y_out is written to y_hist[wptr];
  - wptr increments, wrapping HIST-1 to 0;
  - the FSM returns to IDLE.
- **Arithmetic:**
  - Products are 16x16 giving 32-bit Q8.24.
  - acc is 40-bit signed, which cannot overflow for NB+NA ≤ 16.
  - The shift is arithmetic with truncation toward -inf.
  - Saturation limits are 0x7FFF and 0x8000.
- **Configuration:**
  - cfg_we is accepted only in IDLE. Writes in MAC or OUT are dropped and cfg_err pulses.
  - A write to cfg_addr ≥ NB+NA is dropped and cfg_err pulses.
  - cfg_we and an accepted in_valid in the same IDLE cycle are both taken. The new coefficient applies to that sample.
- **Reset:** all coefficients, delays, history entries, wptr, acc and tap clear to 0. The FSM goes to IDLE. Outputs: in_ready=1, out_valid=0, y_out=0, y_sat=0, cfg_err=0, busy=0.
- Reset asserted in MAC or OUT aborts immediately. The partial sample is discarded and no history is written.

## Timing
- Sample accepted at edge 0. MAC occupies cycles 1..NB+NA. out_valid rises at cycle NB+NA+1. With defaults, that is cycle 10.
- Minimum initiation interval is NB+NA+2 cycles when out_ready is held high.
- in_ready is low from the acceptance edge until the cycle after the output handshake, so it is never combinationally dependent on out_ready.
- Output backpressure stalls indefinitely. y_out, y_sat and out_valid do not change while out_valid=1 and out_ready=0.
- cfg_err is registered: it is high for exactly the cycle after the rejected write.

## Structure
- Shared package iir_pkg holds:
  - Q-format constants (FRAC=12, SAMPLE_W=16, PROD_W=32, ACC_W=40);
  - the FSM state enum;
  - the cfg_data field offsets;
  - the sat16 function.
- One sub-module, iir_mac_unit. Inputs: coefficient, operand, subtract flag, clear, enable. Output: a registered 40-bit acc. The scheduler owns the FSM, buffers, pointers and coefficient registers.

## Test plan
- **Reset:** assert rst mid-MAC → out_valid=0 and busy=0 immediately. After release, in_ready=1 and the first output after a pass-through config equals the input.
- **Pass-through:** slot0 = {d=0, 0x1000}, all other slots zero. x=0x0800 → y_out=0x0800 with out_valid at cycle 10.
- **Sparse delay:** slot0 = {d=6, 0x1000}. Impulse 0x1000 then zeros → outputs 0,0,0,0,0,0,0x1000,0,... Continue past 16 samples → zeros after wrap, with no stale echo.
- **Feedback:** slot0 = {0, 0x1000}, slot3 = {d=1, 0x0800}. Impulse 0x1000 → 0x1000, 0xF800, 0x0400, 0xFE00. The same config with slot3 d=0 → 0x1000, 0, 0.
- **Saturation:** slots 0 and 1 = {0, 0x7FFF}, x=0x7FFF → y_out=0x7FFF, y_sat=1. The same with x=0x8000 → y_out=0x8000, y_sat=1.
- **Backpressure and config:**
  - out_ready low for 5 cycles → y_out stable and in_ready=0 throughout.
  - cfg_we during MAC → cfg_err pulses once and later results are unchanged.
  - cfg_addr=12 in IDLE → cfg_err pulses.
